// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and helpers for the instruction-fetch sequencer.
//   - fetch_state_e : sequencer states (IDLE, FETCH, DRAIN, HALT)
//   - PC_W_DEF / INSTR_W_DEF : default address and instruction widths
//   - fetch_entry_t : one prefetch-buffer entry {pc, instr} at default widths
//   - sat_inc16     : saturating 16-bit increment for the performance counters
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_entry_t;

    // Counter that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// Two-entry prefetch FIFO holding {pc, instr} pairs between instruction memory
// and decode. Entry 0 is always the head; a pop shifts entry 1 down.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   push_i, pop_i     : enqueue push_pc_i/push_instr_i, dequeue the head
//   flush_i           : discard all entries (overrides push and pop)
//   push_pc_i         : word address of the pushed instruction
//   push_instr_i      : pushed instruction word
//   count_o           : number of valid entries (0..2)
//   head_pc_o         : head word address, 0 when empty
//   head_instr_o      : head instruction, 0 when empty
// The caller guarantees no push into a full buffer without a same-cycle pop
// and no pop from an empty buffer.
// -----------------------------------------------------------------------------
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [PC_W-1:0]    push_pc_i,
    input  logic [INSTR_W-1:0] push_instr_i,
    output logic [1:0]         count_o,
    output logic [PC_W-1:0]    head_pc_o,
    output logic [INSTR_W-1:0] head_instr_o
);

    logic [1:0]         count_q, count_d;
    logic [1:0]         count_after_pop;
    logic [PC_W-1:0]    e0_pc_q, e1_pc_q;
    logic [INSTR_W-1:0] e0_instr_q, e1_instr_q;

    // Occupancy once this cycle's pop has been taken; the push lands there.
    assign count_after_pop = count_q - {1'b0, pop_i};

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            count_d = count_after_pop + {1'b0, push_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (!flush_i) begin
            if (pop_i) begin
                e0_pc_q    <= e1_pc_q;
                e0_instr_q <= e1_instr_q;
            end
            if (push_i) begin
                if (count_after_pop == 2'd0) begin
                    e0_pc_q    <= push_pc_i;
                    e0_instr_q <= push_instr_i;
                end else begin
                    e1_pc_q    <= push_pc_i;
                    e1_instr_q <= push_instr_i;
                end
            end
        end
    end

    assign count_o      = count_q;
    assign head_pc_o    = (count_q != 2'd0) ? e0_pc_q    : '0;
    assign head_instr_o = (count_q != 2'd0) ? e0_instr_q : '0;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch controller for the single-cycle MIPS datapath. Owns the
// fetch PC, drives the combinational instruction memory, prefetches into a
// 2-entry buffer and hands instructions to decode over valid/ready. Accepts
// redirects from execute and halts once the fetch PC leaves the program image.
//
// Optional feature macro: FETCH_PERF_EN
//   defined     -> fetch_cnt counts pops, redirect_cnt counts accepted
//                  redirects; both saturate and clear on reset and start.
//   not defined -> both counters read 0.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : pulse; begins fetching at RESET_PC from IDLE or HALT
//   imem_addr       : registered fetch PC to instruction memory
//   imem_data       : combinational word for imem_addr
//   instr, instr_pc : buffer head instruction and its word address
//   instr_valid     : buffer non-empty
//   instr_ready     : decode accepts the head this cycle
//   redirect_valid  : control-flow change this cycle
//   redirect_pc     : redirect target word address
//   busy, done      : state is FETCH/DRAIN, state is HALT
//   fetch_cnt       : instructions delivered
//   redirect_cnt    : redirects taken
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int PROG_LEN = 14,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               busy,
    output logic               done,
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        redirect_cnt
);

    localparam logic [PC_W-1:0] END_PC   = PC_W'(PROG_LEN);
    localparam logic [PC_W-1:0] START_PC = PC_W'(RESET_PC);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic            busy_q, done_q;

    logic [1:0]      buf_count;
    logic            buf_push, buf_pop, buf_flush;

    assign buf_pop = instr_valid & instr_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        buf_push   = 1'b0;
        buf_flush  = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    buf_flush  = 1'b1;
                    fetch_pc_d = START_PC;
                    state_d    = FETCH;
                end
            end
            FETCH, DRAIN: begin
                if (redirect_valid) begin
                    // Redirect beats both push and drain completion; a pop in
                    // this cycle has already been consumed by decode.
                    buf_flush  = 1'b1;
                    fetch_pc_d = redirect_pc;
                    state_d    = (redirect_pc < END_PC) ? FETCH : DRAIN;
                end else if (state_q == FETCH) begin
                    if (fetch_pc_q >= END_PC) begin
                        state_d = DRAIN;
                    end else if (buf_count != 2'd2 || buf_pop) begin
                        buf_push   = 1'b1;
                        fetch_pc_d = fetch_pc_q + PC_W'(1);
                    end
                end else if (buf_count == 2'd0) begin
                    state_d = HALT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= START_PC;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            busy_q     <= (state_d == FETCH) || (state_d == DRAIN);
            done_q     <= (state_d == HALT);
        end
    end

    fetch_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (buf_push),
        .pop_i        (buf_pop),
        .flush_i      (buf_flush),
        .push_pc_i    (fetch_pc_q),
        .push_instr_i (imem_data),
        .count_o      (buf_count),
        .head_pc_o    (instr_pc),
        .head_instr_o (instr)
    );

    assign instr_valid = (buf_count != 2'd0);
    assign imem_addr   = fetch_pc_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_q, redirect_cnt_q;
    logic        start_take, redir_take;

    assign start_take = start && (state_q == IDLE || state_q == HALT);
    assign redir_take = redirect_valid && (state_q == FETCH || state_q == DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q    <= 16'd0;
            redirect_cnt_q <= 16'd0;
        end else if (start_take) begin
            fetch_cnt_q    <= 16'd0;
            redirect_cnt_q <= 16'd0;
        end else begin
            if (buf_pop) begin
                fetch_cnt_q <= sat_inc16(fetch_cnt_q);
            end
            if (redir_take) begin
                redirect_cnt_q <= sat_inc16(redirect_cnt_q);
            end
        end
    end

    assign fetch_cnt    = fetch_cnt_q;
    assign redirect_cnt = redirect_cnt_q;
`else
    assign fetch_cnt    = 16'd0;
    assign redirect_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_DRAIN = 2;
    localparam int M_HALT  = 3;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        busy;
    logic        done;
    logic [15:0] fetch_cnt;
    logic [15:0] redirect_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [0:15];

    fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .done           (done),
        .fetch_cnt      (fetch_cnt),
        .redirect_cnt   (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational program image; junk outside it must never be delivered.
    assign imem_data = (imem_addr < 8'd14) ? mem[imem_addr[3:0]] : 32'hDEADBEEF;

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [7:0]  pc;
        logic [31:0] word;
    } ent_t;

    ent_t       mq[$];
    int         m_mode;
    logic [7:0] m_pc;
    int         m_fcnt;
    int         m_rcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_mode = M_IDLE;
            m_pc   = 8'd0;
            m_fcnt = 0;
            m_rcnt = 0;
        end else begin
            int  had;
            bit  pop;
            had = mq.size();
            pop = (had > 0) && instr_ready;
            if (m_mode == M_IDLE || m_mode == M_HALT) begin
                if (start) begin
                    m_pc = 8'd0;
                    mq.delete();
                    m_mode = M_FETCH;
                    m_fcnt = 0;
                    m_rcnt = 0;
                end
            end else begin
                if (pop) begin
                    void'(mq.pop_front());
                    if (m_fcnt < 65535) m_fcnt++;
                end
                if (redirect_valid) begin
                    mq.delete();
                    m_pc   = redirect_pc;
                    m_mode = (redirect_pc < 8'd14) ? M_FETCH : M_DRAIN;
                    if (m_rcnt < 65535) m_rcnt++;
                end else if (m_mode == M_FETCH) begin
                    if (m_pc >= 8'd14) begin
                        m_mode = M_DRAIN;
                    end else if (mq.size() < 2) begin
                        ent_t e;
                        e.pc   = m_pc;
                        e.word = mem[m_pc[3:0]];
                        mq.push_back(e);
                        m_pc = m_pc + 8'd1;
                    end
                end else if (had == 0) begin
                    m_mode = M_HALT;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare + delivery log ----------------
    logic [7:0] delivered[$];

    always @(negedge clk) begin
        logic        ev;
        logic [31:0] ei;
        logic [7:0]  ep;
        ev = (mq.size() > 0);
        ei = ev ? mq[0].word : 32'd0;
        ep = ev ? mq[0].pc : 8'd0;
        chk("valid", {31'd0, instr_valid}, {31'd0, ev});
        chk("instr", instr, ei);
        chk("instr_pc", {24'd0, instr_pc}, {24'd0, ep});
        chk("imem_addr", {24'd0, imem_addr}, {24'd0, m_pc});
        chk("busy", {31'd0, busy}, (m_mode == M_FETCH || m_mode == M_DRAIN) ? 32'd1 : 32'd0);
        chk("done", {31'd0, done}, (m_mode == M_HALT) ? 32'd1 : 32'd0);
`ifdef FETCH_PERF_EN
        chk("fetch_cnt", {16'd0, fetch_cnt}, m_fcnt);
        chk("redirect_cnt", {16'd0, redirect_cnt}, m_rcnt);
`else
        chk("fetch_cnt", {16'd0, fetch_cnt}, 32'd0);
        chk("redirect_cnt", {16'd0, redirect_cnt}, 32'd0);
`endif
        if (rst_n && instr_valid && instr_ready) delivered.push_back(instr_pc);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int i;
        i = 0;
        while (!done && i < max_cycles) begin
            tick();
            i++;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic chk_seq(input string name, input logic [7:0] exp[$]);
        chk({name, "_len"}, delivered.size(), exp.size());
        for (int i = 0; i < exp.size() && i < delivered.size(); i++)
            chk(name, {24'd0, delivered[i]}, {24'd0, exp[i]});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, {24'd0, imem_addr}, 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_pc"}, {24'd0, instr_pc}, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_fcnt"}, {16'd0, fetch_cnt}, 32'd0);
        chk({tag, "_rcnt"}, {16'd0, redirect_cnt}, 32'd0);
    endtask

    logic [7:0] exp_seq[$];
    logic [31:0] w2;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[2] = 32'h0061202A;
        rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 8'd0;
        #1;
        chk_reset_vals("reset");
        #11 rst_n = 1'b1;
        tick();

        // Straight run, ready high: 0..13 back to back, then halt.
        instr_ready = 1'b1;
        delivered.delete();
        pulse_start();
        tick();
        chk("first_pc", {24'd0, instr_pc}, 32'd0);
        chk("first_valid", {31'd0, instr_valid}, 32'd1);
        tick();
        tick();
        w2 = instr;
        chk("word_pc2", w2, 32'h0061202A);
        wait_done(60);
        chk("run_busy", {31'd0, busy}, 32'd0);
        exp_seq.delete();
        for (int i = 0; i < 14; i++) exp_seq.push_back(8'(i));
        chk_seq("run_seq", exp_seq);

        // Backpressure after start.
        instr_ready = 1'b0;
        delivered.delete();
        pulse_start();
        repeat (4) tick();
        chk("bp_addr", {24'd0, imem_addr}, 32'd2);
        chk("bp_pc", {24'd0, instr_pc}, 32'd0);
        chk("bp_valid", {31'd0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        wait_done(60);
        chk_seq("bp_seq", exp_seq);

        // Redirect to 2 while buffer holds 5 and 6.
        instr_ready = 1'b1;
        delivered.delete();
        pulse_start();
        for (int i = 0; i < 30 && !(instr_valid && instr_pc == 8'd5); i++) tick();
        chk("rd_head5", {24'd0, instr_pc}, 32'd5);
        instr_ready = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 8'd2;
        tick();
        redirect_valid = 1'b0;
        chk("rd_bubble", {31'd0, instr_valid}, 32'd0);
        instr_ready = 1'b1;
        tick();
        chk("rd_target", {24'd0, instr_pc}, 32'd2);
        wait_done(60);
        exp_seq.delete();
        for (int i = 0; i < 5; i++) exp_seq.push_back(8'(i));
        for (int i = 2; i < 14; i++) exp_seq.push_back(8'(i));
        chk_seq("rd_seq", exp_seq);

        // Redirect out of the image, then a redirect while halted.
        pulse_start();
        repeat (3) tick();
        redirect_valid = 1'b1; redirect_pc = 8'd20;
        tick();
        redirect_valid = 1'b0;
        chk("oob_valid", {31'd0, instr_valid}, 32'd0);
        chk("oob_done0", {31'd0, done}, 32'd0);
        tick();
        chk("oob_done1", {31'd0, done}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 8'd3;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("halt_done", {31'd0, done}, 32'd1);
        chk("halt_addr", {24'd0, imem_addr}, 32'd20);
        chk("halt_valid", {31'd0, instr_valid}, 32'd0);

        // Mid-run asynchronous reset at pc 7, then resume.
        pulse_start();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (instr_valid && instr_pc == 8'd7) break;
        end
        chk("mr_head7", {24'd0, instr_pc}, 32'd7);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midreset");
        #1 rst_n = 1'b1;
        tick();
        delivered.delete();
        pulse_start();
        tick();
        chk("resume_pc", {24'd0, instr_pc}, 32'd0);
        wait_done(60);
        exp_seq.delete();
        for (int i = 0; i < 14; i++) exp_seq.push_back(8'(i));
        chk_seq("resume_seq", exp_seq);

        // Full run with one redirect to 12 under random backpressure.
        delivered.delete();
        pulse_start();
        repeat (4) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 8'd12;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        chk("perf_done", {31'd0, done}, 32'd1);
`ifdef FETCH_PERF_EN
        chk("perf_rcnt", {16'd0, redirect_cnt}, 32'd1);
        chk("perf_fcnt", {16'd0, fetch_cnt}, delivered.size());
`else
        chk("perf_rcnt", {16'd0, redirect_cnt}, 32'd0);
        chk("perf_fcnt", {16'd0, fetch_cnt}, 32'd0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 8'($urandom_range(0, 19));
            start          = done ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 31) == 0);
            tick();
        end
        start = 1'b0; redirect_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that sequences the 14-word combinational instruction memory for the single-cycle MIPS datapath. It owns the fetch program counter and drives the memory's 8-bit address. It captures returned words into a 2-entry prefetch buffer and hands them to decode over a valid/ready handshake. It also accepts redirects (beq/bne taken, j/jal, jr) from execute, and stops cleanly when the fetch PC leaves the program image.

## Interface
- PC_W, 8, width of program counter / memory address
- INSTR_W, 32, instruction word width
- PROG_LEN, 14, number of valid words; addresses >= PROG_LEN are out of image
- RESET_PC, 0, fetch PC loaded at reset and on start
- clk  in  1  rising-edge clock (the single clock)
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins fetching at RESET_PC (ignored unless IDLE or HALT)
- imem_addr  out  PC_W  address to instruction memory (registered fetch PC)
- imem_data  in  INSTR_W  combinational word returned for imem_addr
- instr  out  INSTR_W  buffer head instruction
- instr_pc  out  PC_W  word address of instr
- instr_valid  out  1  buffer non-empty
- instr_ready  in  1  decode accepts head this cycle
- redirect_valid  in  1  control-flow change this cycle
- redirect_pc  in  PC_W  word-address target
- busy  out  1  state is FETCH or DRAIN
- done  out  1  state is HALT
- fetch_cnt  out  16  instructions delivered (see Configuration)
- redirect_cnt  out  16  redirects taken (see Configuration)

## Operation
- States: IDLE, FETCH, DRAIN, HALT. Reset -> IDLE.
- IDLE/HALT + start: fetch_pc <= RESET_PC, flush buffer, -> FETCH.
- FETCH: push {fetch_pc, imem_data} when count<2, or count==2 with a pop in the same cycle; on push fetch_pc <= fetch_pc+1 (PC_W wrap, unreachable because of the next rule).
- fetch_pc >= PROG_LEN while in FETCH: no push, -> DRAIN.
- DRAIN: no pushes; -> HALT when buffer empty and no redirect.
- Handshake: pop on instr_valid & instr_ready. instr/instr_pc are stable while valid && !ready.
- Redirect (FETCH or DRAIN), priority over push:
  - A pop in the same cycle completes.
  - All remaining entries are flushed, no push occurs, and fetch_pc <= redirect_pc.
  - Next state is FETCH if redirect_pc < PROG_LEN, else DRAIN (which empties immediately -> HALT next cycle).
- Redirect in IDLE/HALT: ignored. start and redirect both high in FETCH: redirect wins; start ignored.
- Flushed/empty entries read back as instr=0, instr_pc=0.

## Timing
- Reset values:
  - imem_addr=RESET_PC; instr=0, instr_pc=0, instr_valid=0; busy=0, done=0; counters 0.
- start sampled at edge N: FETCH after N; first push at N+1; instr_valid=1 after N+1.
- With ready held high: one instruction per cycle, zero bubbles.
- Redirect sampled at edge M: instr_valid=0 after M; target word valid after M+1 (1 bubble).
- Reset asserted mid-operation clears everything immediately (async); start is needed to resume.

## Configuration
- FETCH_PERF_EN defined:
  - fetch_cnt increments on each pop; redirect_cnt increments on each accepted redirect.
  - Both counters saturate at 16'hFFFF and clear on reset and on start.
- Not defined: counters are not built, and fetch_cnt/redirect_cnt are tied to 0.

## Structure
- Package fetch_pkg: state enum (IDLE, FETCH, DRAIN, HALT), PC_W/INSTR_W defaults, and a buffer-entry struct {pc, instr}.
- Sub-module fetch_buf: 2-entry FIFO with push, pop, flush, count, and head outputs. It holds no PC logic.

## Test plan
- Reset then start, ready=1: instr_pc sequence 0,1,...,13 on consecutive cycles; instr at pc 2 = 32'h0061202A; DRAIN then done=1; busy=0.
- Backpressure: ready=0 for 5 cycles after start -> count stays 2, instr_pc=0 held, imem_addr=2; then ready=1 -> pcs 0,1,2,... with no gaps or repeats.
- Redirect with buffer full: redirect_pc=2 while head pc=5 -> one bubble, then pcs 2,3,4,...; pc 6 never delivered.
- Redirect out of image: redirect_pc=8'd20 -> instr_valid=0, done=1 two cycles later. Redirect while HALT is ignored.
- Mid-run reset: rst_n low at pc 7 -> all outputs return to reset values in the same cycle. start -> delivery resumes at pc 0.
- FETCH_PERF_EN: full run with 1 redirect (to 12) -> redirect_cnt=1, and fetch_cnt = deliveries counted by the bench. Without the macro, both counters read 0.
